// File: rtl/gamecube_pkg.sv
// rtl/gamecube_pkg.sv - shared state encoding and vbit patterns for the GameCube transmitter
package gamecube_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_STOP = 2'd2
    } tx_state_t;

    localparam int VBITS_PER_BIT = 4;

    // Patterns are written vbit0 first, so vbit0 lives in bit 3.
    localparam logic [3:0] VBIT_PATTERN_ZERO = 4'b0001;
    localparam logic [3:0] VBIT_PATTERN_ONE  = 4'b0111;
    localparam logic [3:0] VBIT_PATTERN_STOP = VBIT_PATTERN_ONE;

    function automatic logic vbit_value(input logic [1:0] idx, input logic [3:0] pattern);
        return pattern[2'd3 - idx];
    endfunction

endpackage

// File: rtl/gamecube_vbit_timer.sv
// rtl/gamecube_vbit_timer.sv - virtual-bit prescaler and vbit index within a bit
module gamecube_vbit_timer
    import gamecube_pkg::*;
#(
    parameter int CLKS_PER_VBIT = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       clear,
    output logic       vbit_strobe,
    output logic [1:0] vbit_idx,
    output logic       bit_strobe
);

    generate
        if (CLKS_PER_VBIT == 1) begin : g_no_prescale
            assign vbit_strobe = !clear;
        end else begin : g_prescale
            localparam int CNT_W = $clog2(CLKS_PER_VBIT);
            logic [CNT_W-1:0] cnt;

            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    cnt <= '0;
                end else if (clear || vbit_strobe) begin
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign vbit_strobe = !clear && (cnt == CNT_W'(CLKS_PER_VBIT - 1));
        end
    endgenerate

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            vbit_idx <= 2'd0;
        end else if (clear) begin
            vbit_idx <= 2'd0;
        end else if (vbit_strobe) begin
            vbit_idx <= vbit_idx + 2'd1;
        end
    end

    assign bit_strobe = vbit_strobe && (vbit_idx == 2'(VBITS_PER_BIT - 1));

endmodule

// File: rtl/gamecube_frame_transmitter.sv
// rtl/gamecube_frame_transmitter.sv - frame serialiser with 4-vbit GameCube line encoding
module gamecube_frame_transmitter
    import gamecube_pkg::*;
#(
    parameter int DATA_WIDTH    = 24,
    parameter int CLKS_PER_VBIT = 1,
    parameter int LEN_WIDTH     = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] TX_DATA,
    input  logic [LEN_WIDTH-1:0]  TX_LEN,
    input  logic                  TX_VALID,
    output logic                  TX_READY,
    output logic                  DATALINE,
    output logic                  BUSY,
    output logic                  DONE
);

    tx_state_t             state, state_nxt;
    logic [DATA_WIDTH-1:0] shift, shift_nxt;
    logic [LEN_WIDTH-1:0]  bits_left, bits_left_nxt;
    logic                  line_nxt, busy_nxt, done_nxt, ready_nxt;
    logic [LEN_WIDTH-1:0]  len_clamped;
    logic                  vbit_strobe, bit_strobe;
    logic [1:0]            vbit_idx;

    gamecube_vbit_timer #(
        .CLKS_PER_VBIT(CLKS_PER_VBIT)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .clear      (state == ST_IDLE),
        .vbit_strobe(vbit_strobe),
        .vbit_idx   (vbit_idx),
        .bit_strobe (bit_strobe)
    );

    assign len_clamped = (TX_LEN > LEN_WIDTH'(DATA_WIDTH)) ? LEN_WIDTH'(DATA_WIDTH) : TX_LEN;

    always_comb begin
        state_nxt     = state;
        shift_nxt     = shift;
        bits_left_nxt = bits_left;
        line_nxt      = DATALINE;
        busy_nxt      = BUSY;
        done_nxt      = 1'b0;
        ready_nxt     = TX_READY;
        case (state)
            ST_IDLE: begin
                line_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
                // The first vbit goes out on the accept edge itself.
                if (TX_VALID && TX_READY) begin
                    shift_nxt     = TX_DATA;
                    bits_left_nxt = len_clamped;
                    line_nxt      = 1'b0;
                    busy_nxt      = 1'b1;
                    ready_nxt     = 1'b0;
                    state_nxt     = (len_clamped == '0) ? ST_STOP : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    shift_nxt     = shift << 1;
                    bits_left_nxt = bits_left - 1'b1;
                    line_nxt      = 1'b0;
                    if (bits_left == LEN_WIDTH'(1)) begin
                        state_nxt = ST_STOP;
                    end
                end else if (vbit_strobe) begin
                    line_nxt = vbit_value(vbit_idx + 2'd1,
                                          shift[DATA_WIDTH-1] ? VBIT_PATTERN_ONE : VBIT_PATTERN_ZERO);
                end
            end
            ST_STOP: begin
                if (bit_strobe) begin
                    state_nxt = ST_IDLE;
                    line_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                end else if (vbit_strobe) begin
                    line_nxt = vbit_value(vbit_idx + 2'd1, VBIT_PATTERN_STOP);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            shift     <= '0;
            bits_left <= '0;
            DATALINE  <= 1'b1;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            TX_READY  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift     <= shift_nxt;
            bits_left <= bits_left_nxt;
            DATALINE  <= line_nxt;
            BUSY      <= busy_nxt;
            DONE      <= done_nxt;
            TX_READY  <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_gamecube_frame_transmitter.sv
// tb/tb_gamecube_frame_transmitter.sv - self-checking bench for gamecube_frame_transmitter
module tb_gamecube_frame_transmitter;

    localparam int DW = 24;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] tx_data [2];
    logic [LW-1:0] tx_len  [2];
    logic [1:0]    tx_valid;
    logic [1:0]    tx_ready, dataline, busy, done;

    int errors = 0;
    int checks = 0;

    logic exp_line [2][512];
    int   m_n[2], m_pos[2], m_frames[2];
    logic m_ready[2], m_busy[2], m_done[2], m_line[2];
    int   busy_cnt[2], exp_busy[2];

    always #5 clk = ~clk;

    gamecube_frame_transmitter #(.DATA_WIDTH(DW), .CLKS_PER_VBIT(1)) dut0 (
        .CLK(clk), .RST(rst), .TX_DATA(tx_data[0]), .TX_LEN(tx_len[0]), .TX_VALID(tx_valid[0]),
        .TX_READY(tx_ready[0]), .DATALINE(dataline[0]), .BUSY(busy[0]), .DONE(done[0]));

    gamecube_frame_transmitter #(.DATA_WIDTH(DW), .CLKS_PER_VBIT(4)) dut1 (
        .CLK(clk), .RST(rst), .TX_DATA(tx_data[1]), .TX_LEN(tx_len[1]), .TX_VALID(tx_valid[1]),
        .TX_READY(tx_ready[1]), .DATALINE(dataline[1]), .BUSY(busy[1]), .DONE(done[1]));

    task automatic check(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[dut%0d] t=%0t: got %0h expected %0h", nm, i, $time, act, exp);
        end
    endtask

    // Expected line waveform straight from the encoding rules: payload bits MSB first, then stop.
    task automatic load(input int i);
        int c, len, k, bitv, val;
        c   = (i == 0) ? 1 : 4;
        len = (int'(tx_len[i]) > DW) ? DW : int'(tx_len[i]);
        k   = 0;
        for (int b = 0; b <= len; b++) begin
            bitv = (b < len) ? int'(tx_data[i][DW-1-b]) : 1;
            for (int v = 0; v < 4; v++) begin
                val = (v == 0) ? 0 : (v == 3) ? 1 : bitv;
                for (int r = 0; r < c; r++) begin
                    exp_line[i][k] = val[0];
                    k++;
                end
            end
        end
        m_n[i] = k;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_ready[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_line[i] = 1;
            m_pos[i] = 0; m_n[i] = 0; m_frames[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_ready[i] = 0; m_busy[i] = 0; m_done[i] = 0; m_line[i] = 1;
                end else begin
                    m_done[i] = 0;
                    if (m_busy[i]) begin
                        m_pos[i]++;
                        if (m_pos[i] == m_n[i]) begin
                            m_busy[i] = 0; m_done[i] = 1; m_ready[i] = 1; m_line[i] = 1;
                        end else begin
                            m_line[i] = exp_line[i][m_pos[i]];
                        end
                    end else if (m_ready[i] && tx_valid[i]) begin
                        load(i);
                        m_pos[i] = 0; m_line[i] = exp_line[i][0];
                        m_busy[i] = 1; m_ready[i] = 0; m_frames[i]++;
                    end else begin
                        m_ready[i] = 1;
                    end
                end
            end
        end
    end

    initial begin
        busy_cnt[0] = 0; busy_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                check("dataline", i, 32'(dataline[i]), 32'(m_line[i]));
                check("busy", i, 32'(busy[i]), 32'(m_busy[i]));
                check("done", i, 32'(done[i]), 32'(m_done[i]));
                check("tx_ready", i, 32'(tx_ready[i]), 32'(m_ready[i]));
                if (rst) busy_cnt[i] = 0;
                else if (busy[i]) busy_cnt[i]++;
                if (done[i]) begin
                    check("busy_len", i, 32'(busy_cnt[i]), 32'(exp_busy[i]));
                    busy_cnt[i] = 0;
                end
            end
        end
    end

    task automatic send(input int i, input logic [DW-1:0] d, input logic [LW-1:0] l, input int eb);
        int t;
        exp_busy[i] = eb;
        tx_data[i]  = d;
        tx_len[i]   = l;
        tx_valid[i] = 1'b1;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!m_busy[i] && t < 50);
        if (t >= 50) check("accept_timeout", i, 0, 1);
        tx_valid[i] = 1'b0;
        tx_data[i]  = ~d;
        tx_len[i]   = 5'd3;
        t = 0;
        do begin @(posedge clk); #1; t++; end while (!m_done[i] && t < 1000);
        if (t >= 1000) check("done_timeout", i, 0, 1);
    endtask

    initial begin
        int t, f0;
        for (int i = 0; i < 2; i++) begin
            tx_data[i] = '0; tx_len[i] = '0; exp_busy[i] = 0;
        end
        tx_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("idle_ready", 0, 32'(tx_ready[0]), 1);
        check("idle_line", 0, 32'(dataline[0]), 1);

        send(0, 24'h400300, 5'd24, 100);
        check("model_len", 0, 32'(m_n[0]), 100);
        for (int k = 0; k < 8; k++) begin
            check("model_head", k, 32'(exp_line[0][k]), 32'((8'b00010111 >> (7 - k)) & 1));
            check("model_tail", k, 32'(exp_line[0][92+k]), 32'((8'b00010111 >> (7 - k)) & 1));
        end

        send(1, 24'hA5_1234, 5'd8, 144);
        check("model_len", 1, 32'(m_n[1]), 144);
        send(0, 24'hFFFFFF, 5'd0, 4);
        send(1, 24'h000000, 5'd0, 16);
        send(0, 24'h400300, 5'd31, 100);
        send(1, 24'h5A0000, 5'd31, 400);

        exp_busy[0] = 100;
        tx_data[0]  = 24'hC0FFEE;
        tx_len[0]   = 5'd24;
        tx_valid[0] = 1'b1;
        f0 = m_frames[0];
        t = 0;
        do begin @(posedge clk); #1; t++; end while (m_frames[0] < f0 + 2 && t < 300);
        if (t >= 300) check("b2b_timeout", 0, 0, 1);
        repeat (13) @(posedge clk);
        #1;
        check("busy_before_rst", 0, 32'(busy[0]), 1);
        rst = 1'b1;
        tx_valid[0] = 1'b0;
        #1;
        check("rst_line", 0, 32'(dataline[0]), 1);
        check("rst_busy", 0, 32'(busy[0]), 0);
        check("rst_done", 0, 32'(done[0]), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 check("ready_pre_edge", 0, 32'(tx_ready[0]), 0);
        @(posedge clk);
        #1 check("ready_after_rst", 0, 32'(tx_ready[0]), 1);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
